// File: rtl/pwm_channel_scheduler_pkg.sv
// Shared types and defaults for the PWM channel scheduler: FSM state encoding,
// default window/clear lengths and the wrap-around index helper used by the picker.
package pwm_channel_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_NEXT    = 3'd4
  } sched_state_t;

  localparam int DEFAULT_NUM_CHANNELS  = 4;
  localparam int DEFAULT_CHANNEL_WIDTH = 2;
  localparam int DEFAULT_WINDOW_CYCLES = 2000;
  localparam int DEFAULT_CLEAR_CYCLES  = 2;

  // base < modulus and offset <= modulus, so one subtraction is enough.
  function automatic int unsigned wrap_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned modulus);
    int unsigned sum;
    sum = base + offset;
    if (sum >= modulus) sum = sum - modulus;
    return sum;
  endfunction

endpackage

// File: rtl/pwm_channel_scheduler_if.sv
// Bundle between the pins / pwm_analyzer and the scheduler. The scheduler owns the
// slave side; whatever drives the PWM inputs and hosts the analyzer owns the master side.
interface pwm_channel_scheduler_if
  import pwm_channel_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
  parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH
);
  logic                     enable_i;
  logic [NUM_CHANNELS-1:0]  channel_mask_i;
  logic [NUM_CHANNELS-1:0]  pwm_i;
  logic                     analyzer_reset_o;
  logic                     analyzer_enable_o;
  logic                     analyzer_pwm_o;
  logic                     analyzer_result_i;
  logic [CHANNEL_WIDTH-1:0] channel_o;
  logic [NUM_CHANNELS-1:0]  result_o;
  logic [NUM_CHANNELS-1:0]  valid_o;
  logic                     done_o;
  logic                     busy_o;

  modport master (
    output enable_i, channel_mask_i, pwm_i, analyzer_result_i,
    input  analyzer_reset_o, analyzer_enable_o, analyzer_pwm_o,
    input  channel_o, result_o, valid_o, done_o, busy_o
  );

  modport slave (
    input  enable_i, channel_mask_i, pwm_i, analyzer_result_i,
    output analyzer_reset_o, analyzer_enable_o, analyzer_pwm_o,
    output channel_o, result_o, valid_o, done_o, busy_o
  );

endinterface

// File: rtl/pwm_channel_scheduler_picker.sv
// Round-robin channel picker: first masked-in index starting at i_current
// (inclusive) or strictly after it (exclusive), wrapping around once.
module rr_channel_picker
  import pwm_channel_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
  parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH
) (
  input  logic [NUM_CHANNELS-1:0]  i_mask,
  input  logic [CHANNEL_WIDTH-1:0] i_current,
  input  logic                     i_inclusive,
  output logic [CHANNEL_WIDTH-1:0] o_next,
  output logic                     o_found
);

  // Offset NUM_CHANNELS lands back on i_current, so a lone enabled channel
  // is still found in exclusive mode.
  always_comb begin
    int unsigned w_idx;
    w_idx   = 0;
    o_next  = i_current;
    o_found = 1'b0;
    for (int off = 0; off <= NUM_CHANNELS; off++) begin
      w_idx = wrap_index(32'(i_current), off, NUM_CHANNELS);
      if (!o_found && (off != 0 || i_inclusive) && i_mask[CHANNEL_WIDTH'(w_idx)]) begin
        o_found = 1'b1;
        o_next  = CHANNEL_WIDTH'(w_idx);
      end
    end
  end

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Time-multiplexes one pwm_analyzer over NUM_CHANNELS inputs: per channel it clears
// the analyzer, gates it for a fixed window, then latches the verdict per channel.
module pwm_channel_scheduler
  import pwm_channel_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
  parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int CLEAR_CYCLES  = DEFAULT_CLEAR_CYCLES
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  pwm_channel_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES - 1);

  sched_state_t             r_state;
  logic [CHANNEL_WIDTH-1:0] r_channel;
  logic [CNT_W-1:0]         r_count;
  logic                     r_an_reset;
  logic                     r_an_enable;
  logic                     r_done;
  logic                     r_busy;

  logic [CHANNEL_WIDTH-1:0] w_pick_next;
  logic                     w_pick_found;
  logic                     w_latch;
  logic [NUM_CHANNELS-1:0]  w_result;
  logic [NUM_CHANNELS-1:0]  w_valid;

  rr_channel_picker #(
    .NUM_CHANNELS  (NUM_CHANNELS),
    .CHANNEL_WIDTH (CHANNEL_WIDTH)
  ) u_picker (
    .i_mask      (bus.channel_mask_i),
    .i_current   (r_channel),
    .i_inclusive (r_state == ST_IDLE),
    .o_next      (w_pick_next),
    .o_found     (w_pick_found)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_channel   <= '0;
      r_count     <= '0;
      r_an_reset  <= 1'b1;
      r_an_enable <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.enable_i && w_pick_found) begin
            r_channel  <= w_pick_next;
            r_count    <= CLEAR_LOAD;
            r_an_reset <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_CLEAR;
          end
        end
        ST_CLEAR, ST_MEASURE: begin
          if (!bus.enable_i) begin
            r_an_reset  <= 1'b1;
            r_an_enable <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else if (r_state == ST_CLEAR) begin
            r_count     <= WINDOW_LOAD;
            r_an_reset  <= 1'b0;
            r_an_enable <= 1'b1;
            r_state     <= ST_MEASURE;
          end else begin
            r_an_enable <= 1'b0;
            r_state     <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_done  <= 1'b1;
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          // Analyzer reset stays low in NEXT so it is high for exactly the CLEAR cycles between windows.
          r_an_reset <= 1'b1;
          if (bus.enable_i && w_pick_found) begin
            r_channel <= w_pick_next;
            r_count   <= CLEAR_LOAD;
            r_state   <= ST_CLEAR;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_an_reset  <= 1'b1;
          r_an_enable <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_latch = (r_state == ST_SAMPLE);

  // A masked-out channel loses its verdict, and a window finishing on it is dropped.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_result
    logic r_result_bit;
    logic r_valid_bit;

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        r_result_bit <= 1'b0;
        r_valid_bit  <= 1'b0;
      end else if (!bus.channel_mask_i[gi]) begin
        r_result_bit <= 1'b0;
        r_valid_bit  <= 1'b0;
      end else if (w_latch && r_channel == CHANNEL_WIDTH'(gi)) begin
        r_result_bit <= bus.analyzer_result_i;
        r_valid_bit  <= 1'b1;
      end
    end

    assign w_result[gi] = r_result_bit;
    assign w_valid[gi]  = r_valid_bit;
  end

  assign bus.analyzer_reset_o  = r_an_reset;
  assign bus.analyzer_enable_o = r_an_enable;
  assign bus.analyzer_pwm_o    = bus.pwm_i[r_channel];
  assign bus.channel_o         = r_channel;
  assign bus.result_o          = w_result;
  assign bus.valid_o           = w_valid;
  assign bus.done_o            = r_done;
  assign bus.busy_o            = r_busy;

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Bench for pwm_channel_scheduler with a behavioural majority-vote analyzer and a
// scoreboard of expected (channel, verdict) pairs popped on every done pulse.
module tb_pwm_channel_scheduler;

  localparam int N      = 4;
  localparam int CW     = 2;
  localparam int W      = 16;
  localparam int C      = 2;
  localparam int PERIOD = C + W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_channel_scheduler_if #(.NUM_CHANNELS(N), .CHANNEL_WIDTH(CW)) bus ();

  pwm_channel_scheduler #(
    .NUM_CHANNELS  (N),
    .CHANNEL_WIDTH (CW),
    .WINDOW_CYCLES (W),
    .CLEAR_CYCLES  (C)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  // Analyzer model: counts high samples while enabled, verdict is a majority.
  int an_cnt = 0;
  always @(posedge clk) begin
    if (bus.analyzer_reset_o) an_cnt <= 0;
    else if (bus.analyzer_enable_o && bus.analyzer_pwm_o) an_cnt <= an_cnt + 1;
  end
  assign bus.analyzer_result_i = (an_cnt > W / 2);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int ch;
    bit res;
  } exp_t;
  exp_t q[$];
  exp_t e;

  task automatic push(input int ch, input bit res);
    exp_t x;
    x.ch  = ch;
    x.res = res;
    q.push_back(x);
  endtask

  int cyc = 0;
  int done_count = 0;
  int last_done = 0;
  bit gap_ok = 0;
  int rst_run = 0;
  bit run_from_next = 0;
  bit prev_done = 0;
  bit prev_anrst = 1;
  bit prev_anen = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      if (bus.done_o) begin
        done_count++;
        chk("done_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          $display("done #%0d: ch=%0d result=%0b (exp ch=%0d result=%0b)",
                   done_count, bus.channel_o, bus.result_o[e.ch], e.ch, e.res);
          chk("done_channel", 32'(bus.channel_o), e.ch);
          chk("done_result", 32'(bus.result_o[e.ch]), 32'(e.res));
          chk("done_valid", 32'(bus.valid_o[e.ch]), 1);
        end
        if (gap_ok) chk("done_period", cyc - last_done, PERIOD);
        last_done = cyc;
        gap_ok = 1;
      end
      if (!bus.busy_o) run_from_next = 0;
      if (bus.analyzer_reset_o && !prev_anrst) begin
        run_from_next = prev_done;
        rst_run = 0;
      end
      if (bus.analyzer_reset_o) rst_run++;
      if (bus.analyzer_enable_o && !prev_anen && run_from_next)
        chk("clear_len", rst_run, C);
      prev_done  = bus.done_o;
      prev_anrst = bus.analyzer_reset_o;
      prev_anen  = bus.analyzer_enable_o;
    end
  end

  task automatic wait_dones(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_count >= target) return;
    end
    chk("timeout_done", done_count, target);
  endtask

  task automatic wait_measure(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.analyzer_enable_o) return;
    end
    chk("timeout_measure", 32'(bus.analyzer_enable_o), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_channel"}, 32'(bus.channel_o), 0);
    chk({tag, "_an_reset"}, 32'(bus.analyzer_reset_o), 1);
    chk({tag, "_an_enable"}, 32'(bus.analyzer_enable_o), 0);
    chk({tag, "_result"}, 32'(bus.result_o), 0);
    chk({tag, "_valid"}, 32'(bus.valid_o), 0);
    chk({tag, "_done"}, 32'(bus.done_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
  endtask

  int base;
  int en_cyc;
  int dc;

  initial begin
    bus.enable_i       = 1'b0;
    bus.channel_mask_i = '0;
    bus.pwm_i          = '0;
    #1 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full rotation over all four channels
    bus.channel_mask_i = 4'b1111;
    bus.pwm_i          = 4'b0101;
    push(0, 1); push(1, 0); push(2, 1); push(3, 0); push(0, 1);
    base   = done_count;
    gap_ok = 0;
    en_cyc = cyc;
    bus.enable_i = 1'b1;
    wait_dones(base + 1, 2 * PERIOD);
    chk("t1_latency", last_done - en_cyc, PERIOD);
    wait_dones(base + 5, 5 * PERIOD + 10);
    chk("t2_result", 32'(bus.result_o), 32'h5);
    chk("t2_valid", 32'(bus.valid_o), 32'hF);
    bus.enable_i = 1'b0;
    gap_ok = 0;
    repeat (3) @(negedge clk);
    chk("t1_idle_busy", 32'(bus.busy_o), 0);
    chk("t1_idle_channel", 32'(bus.channel_o), 0);

    // Sparse mask: odd channels only
    bus.channel_mask_i = 4'b1010;
    bus.pwm_i          = 4'b1000;
    push(1, 0); push(3, 1); push(1, 0); push(3, 1);
    base = done_count;
    bus.enable_i = 1'b1;
    wait_dones(base + 4, 4 * PERIOD + 10);
    bus.enable_i = 1'b0;
    gap_ok = 0;
    repeat (3) @(negedge clk);
    chk("t3_channel", 32'(bus.channel_o), 3);
    chk("t3_result", 32'(bus.result_o), 32'h8);
    chk("t3_valid", 32'(bus.valid_o), 32'hA);

    // Single enabled channel
    bus.channel_mask_i = 4'b0100;
    bus.pwm_i          = 4'b0100;
    push(2, 1); push(2, 1); push(2, 1);
    base = done_count;
    bus.enable_i = 1'b1;
    wait_dones(base + 3, 3 * PERIOD + 10);
    chk("t4_channel", 32'(bus.channel_o), 2);
    chk("t4_valid", 32'(bus.valid_o), 32'h4);
    chk("t4_result", 32'(bus.result_o), 32'h4);
    bus.enable_i = 1'b0;
    gap_ok = 0;
    repeat (3) @(negedge clk);

    // Abort mid-window, then restart the same channel
    bus.channel_mask_i = 4'b0010;
    bus.pwm_i          = 4'b0010;
    push(1, 1);
    base = done_count;
    bus.enable_i = 1'b1;
    wait_dones(base + 1, 2 * PERIOD);
    wait_measure(10);
    repeat (7) @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(bus.busy_o), 0);
    chk("t5_channel", 32'(bus.channel_o), 1);
    chk("t5_valid1", 32'(bus.valid_o[1]), 1);
    chk("t5_result1", 32'(bus.result_o[1]), 1);
    chk("t5_an_reset", 32'(bus.analyzer_reset_o), 1);
    dc = done_count;
    repeat (25) @(negedge clk);
    chk("t5_no_done", done_count, dc);
    bus.pwm_i = 4'b0000;
    push(1, 0);
    base   = done_count;
    gap_ok = 0;
    en_cyc = cyc;
    bus.enable_i = 1'b1;
    wait_dones(base + 1, 2 * PERIOD);
    chk("t5_restart_latency", last_done - en_cyc, PERIOD);
    chk("t5_restart_result1", 32'(bus.result_o[1]), 0);
    bus.enable_i = 1'b0;
    gap_ok = 0;
    repeat (3) @(negedge clk);

    // Mask clear while valid, then asynchronous reset mid-window
    bus.channel_mask_i = 4'b1111;
    bus.pwm_i          = 4'b0100;
    push(1, 0); push(2, 1);
    base = done_count;
    bus.enable_i = 1'b1;
    wait_dones(base + 2, 2 * PERIOD + 10);
    chk("t6_valid2_before", 32'(bus.valid_o[2]), 1);
    bus.channel_mask_i = 4'b1011;
    @(posedge clk);
    #1;
    chk("t6_valid2_cleared", 32'(bus.valid_o[2]), 0);
    chk("t6_result2_cleared", 32'(bus.result_o[2]), 0);
    wait_measure(10);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_async");
    q.delete();
    @(negedge clk);
    bus.enable_i = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
